// File: rtl/diamond_pkg.sv
// Shared constants, FSM state type and pattern-length helper for the diamond stream sequencer.
// Defining DIAMOND_MID_DEDUP_EN makes the widest row appear only once.
package diamond_pkg;

    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_STAR = 8'h2A;
    localparam logic [7:0] ASCII_NL   = 8'h0A;

`ifdef DIAMOND_MID_DEDUP_EN
    localparam bit DEDUP_EN = 1'b1;
`else
    localparam bit DEDUP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LEAD_SP,
        STAR,
        STAR_SP,
        NL,
        FIN
    } state_t;

    // Each row r of a half costs (n-1-r) + 2(r+1) + 1 bytes; the dedup build drops one widest row.
    function automatic int diamond_len(input int n, input bit dedup);
        int per_half;
        per_half = n * (n + 2) + (n * (n - 1)) / 2;
        return dedup ? (2 * per_half - (2 * n + 1)) : (2 * per_half);
    endfunction

endpackage

// File: rtl/diamond_row_calc.sv
// Row geometry: leading-space and "* "-pair counts for a given half and row index.
module diamond_row_calc #(
    parameter int N     = 5,
    parameter int ROW_W = $clog2(N + 1)
) (
    input  logic             half,
    input  logic [ROW_W-1:0] row,
    output logic [ROW_W-1:0] lead_spaces,
    output logic [ROW_W-1:0] star_pairs
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);
    localparam logic [ROW_W-1:0] ROWS     = ROW_W'(N);

    always_comb begin
        if (half) begin
            lead_spaces = row;
            star_pairs  = ROWS - row;
        end else begin
            lead_spaces = LAST_ROW - row;
            star_pairs  = row + ROW_W'(1);
        end
    end

endmodule

// File: rtl/diamond_stream_seq.sv
// Byte-serial star-diamond generator behind a valid/ready source port.
// Build with DIAMOND_MID_DEDUP_EN to emit the middle (widest) row only once.
module diamond_stream_seq
    import diamond_pkg::*;
#(
    parameter int N = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_char,
    output logic       out_last,
    output logic       busy,
    output logic       done
);

    localparam int               ROW_W       = $clog2(N + 1);
    localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(N - 1);
    localparam int               PATTERN_LEN = diamond_len(N, DEDUP_EN);

    state_t           state_reg, state_next;
    logic             half_reg, half_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic [ROW_W-1:0] col_reg, col_next;
    logic             out_valid_reg, out_valid_next;
    logic [7:0]       out_char_reg, out_char_next;
    logic             out_last_reg, out_last_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic             handshake;
    logic             follow_half;
    logic [ROW_W-1:0] follow_row;
    logic             calc_half;
    logic [ROW_W-1:0] calc_row;
    logic [ROW_W-1:0] calc_lead;
    logic [ROW_W-1:0] calc_pairs;

    assign handshake = out_valid_reg & out_ready;

    // With dedup and a single row, the upper half's only row is also the final one.
    function automatic logic at_last_row(input logic h, input logic [ROW_W-1:0] r);
        return (h || (DEDUP_EN && (N == 1))) && (r == LAST_ROW);
    endfunction

    // IDLE and NL look ahead to the row about to start; other states need the current row.
    always_comb begin
        follow_half = half_reg;
        follow_row  = row_reg + ROW_W'(1);
        if (state_reg == IDLE) begin
            follow_half = 1'b0;
            follow_row  = '0;
        end else if (!half_reg && (row_reg == LAST_ROW)) begin
            follow_half = 1'b1;
            follow_row  = DEDUP_EN ? ROW_W'(1) : '0;
        end
        calc_half = half_reg;
        calc_row  = row_reg;
        if ((state_reg == IDLE) || (state_reg == NL)) begin
            calc_half = follow_half;
            calc_row  = follow_row;
        end
    end

    diamond_row_calc #(
        .N     (N),
        .ROW_W (ROW_W)
    ) u_row_calc (
        .half        (calc_half),
        .row         (calc_row),
        .lead_spaces (calc_lead),
        .star_pairs  (calc_pairs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            half_reg      <= 1'b0;
            row_reg       <= '0;
            col_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_char_reg  <= 8'h00;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            half_reg      <= half_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            out_valid_reg <= out_valid_next;
            out_char_reg  <= out_char_next;
            out_last_reg  <= out_last_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        half_next  = half_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    half_next  = follow_half;
                    row_next   = follow_row;
                    col_next   = '0;
                    state_next = (calc_lead == '0) ? STAR : LEAD_SP;
                end
            end
            LEAD_SP: begin
                if (handshake) begin
                    if (col_reg == calc_lead - ROW_W'(1)) begin
                        col_next   = '0;
                        state_next = STAR;
                    end else begin
                        col_next = col_reg + ROW_W'(1);
                    end
                end
            end
            STAR: begin
                if (handshake) begin
                    state_next = STAR_SP;
                end
            end
            STAR_SP: begin
                if (handshake) begin
                    if (col_reg == calc_pairs - ROW_W'(1)) begin
                        col_next   = '0;
                        state_next = NL;
                    end else begin
                        col_next   = col_reg + ROW_W'(1);
                        state_next = STAR;
                    end
                end
            end
            NL: begin
                if (handshake) begin
                    if (at_last_row(half_reg, row_reg)) begin
                        state_next = FIN;
                    end else begin
                        half_next  = follow_half;
                        row_next   = follow_row;
                        state_next = (calc_lead == '0) ? STAR : LEAD_SP;
                    end
                end
            end
            FIN: begin
                half_next  = 1'b0;
                row_next   = '0;
                col_next   = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they register alongside it.
    always_comb begin
        out_valid_next = 1'b0;
        out_char_next  = 8'h00;
        out_last_next  = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        case (state_next)
            LEAD_SP: begin
                out_valid_next = 1'b1;
                out_char_next  = ASCII_SP;
                busy_next      = 1'b1;
            end
            STAR: begin
                out_valid_next = 1'b1;
                out_char_next  = ASCII_STAR;
                busy_next      = 1'b1;
            end
            STAR_SP: begin
                out_valid_next = 1'b1;
                out_char_next  = ASCII_SP;
                busy_next      = 1'b1;
            end
            NL: begin
                out_valid_next = 1'b1;
                out_char_next  = ASCII_NL;
                out_last_next  = at_last_row(half_next, row_next);
                busy_next      = 1'b1;
            end
            FIN: begin
                done_next = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign out_valid = out_valid_reg;
    assign out_char  = out_char_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

`ifndef SYNTHESIS
    logic [15:0] byte_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            byte_cnt_reg <= '0;
        end else if (handshake) begin
            byte_cnt_reg <= byte_cnt_reg + 16'd1;
        end
    end

    a_pattern_len: assert property (@(posedge clk) disable iff (!rst_n)
        (handshake && out_last_reg) |-> (int'(byte_cnt_reg) == PATTERN_LEN - 1));
`endif

endmodule
